uart2apb: RTL and testbench

UART2APB -- requirements
Module: uart2apb

---
 rtl/uart2apb.sv | 108 ++++++++++
 tb/tb_uart2apb.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/uart2apb.sv
// Command-to-APB bridge: one command word in, one APB transfer out, one response back.
// A completer that never raises PREADY is aborted after TIMEOUT_CYCLES wait cycles.
module uart2apb #(
    parameter int unsigned ADDR_WIDTH     = 7,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                              PCLK,
    input  logic                              PRESET,
    input  logic [ADDR_WIDTH+DATA_WIDTH:0]    cmd,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    output logic [ADDR_WIDTH-1:0]             PADDR,
    output logic                              PSEL,
    output logic                              PENABLE,
    output logic                              PWRITE,
    output logic [DATA_WIDTH-1:0]             PWDATA,
    input  logic                              PREADY,
    input  logic [DATA_WIDTH-1:0]             PRDATA,
    input  logic                              PSLVERR,
    output logic [DATA_WIDTH-1:0]             rsp_data,
    output logic                              rsp_err,
    output logic                              rsp_valid,
    input  logic                              rsp_ready
);

    localparam int unsigned CMD_WIDTH = ADDR_WIDTH + DATA_WIDTH + 1;
    localparam int unsigned TO_WIDTH  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t              state;
    logic [TO_WIDTH-1:0] to_cnt;

    assign cmd_ready = (state == IDLE);

    // Transfer sequencer; every APB and response output is a register.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state     <= IDLE;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_data  <= '0;
            to_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        PWRITE <= cmd[CMD_WIDTH-1];
                        PADDR  <= cmd[CMD_WIDTH-2 -: ADDR_WIDTH];
                        PWDATA <= cmd[DATA_WIDTH-1:0];
                        PSEL   <= 1'b1;
                        to_cnt <= '0;
                        state  <= SETUP;
                    end
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    // PREADY takes priority over a timeout firing in the same cycle.
                    if (PREADY) begin
                        rsp_data  <= PWRITE ? '0 : PRDATA;
                        rsp_err   <= PSLVERR;
                        rsp_valid <= 1'b1;
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        state     <= RESP;
                    end else if (to_cnt == TO_LAST) begin
                        rsp_data  <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        state     <= RESP;
                    end else begin
                        to_cnt <= to_cnt + TO_WIDTH'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    PSEL      <= 1'b0;
                    PENABLE   <= 1'b0;
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart2apb.sv
// Self-checking bench for uart2apb: directed vector table, randomized transfers against a
// transaction-level response model, and hand-written reset/back-to-back sequences.
module tb_uart2apb;

    localparam int unsigned AW = 7;
    localparam int unsigned DW = 8;
    localparam int unsigned TO = 16;

    logic                PCLK;
    logic                PRESET;
    logic [AW+DW:0]      cmd;
    logic                cmd_valid;
    logic                cmd_ready;
    logic [AW-1:0]       PADDR;
    logic                PSEL;
    logic                PENABLE;
    logic                PWRITE;
    logic [DW-1:0]       PWDATA;
    logic                PREADY;
    logic [DW-1:0]       PRDATA;
    logic                PSLVERR;
    logic [DW-1:0]       rsp_data;
    logic                rsp_err;
    logic                rsp_valid;
    logic                rsp_ready;

    uart2apb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd(cmd), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
        .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int accept_cyc = 0;

    always @(posedge PCLK) cyc <= cyc + 1;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            ws;      // wait states before PREADY (>= TO means never)
        logic [DW-1:0] prdata;
        logic          perr;
        int            hold;    // cycles rsp_ready stays low
        logic [DW-1:0] e_data;
        logic          e_err;
        int            e_acc;   // expected ACCESS cycles
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Transaction-level reference: what the response must be given how the completer behaved.
    function automatic logic [DW-1:0] ref_data(input logic wr, input int ws, input logic [DW-1:0] prd);
        if (ws >= int'(TO) || wr) return '0;
        return prd;
    endfunction

    function automatic logic ref_err(input int ws, input logic perr);
        return (ws >= int'(TO)) ? 1'b1 : perr;
    endfunction

    function automatic int ref_acc(input int ws);
        return (ws >= int'(TO)) ? int'(TO) : ws + 1;
    endfunction

    task automatic txn(input vec_t v);
        int  acc;
        bit  done;
        bit  unstable;
        logic [DW-1:0] d0;
        logic          e0;
        for (int i = 0; i < 50 && !cmd_ready; i++) @(negedge PCLK);
        check("cmd_ready_before_cmd", 32'(cmd_ready), 32'd1);
        cmd       = {v.wr, v.addr, v.data};
        cmd_valid = 1'b1;
        accept_cyc = cyc;
        @(negedge PCLK);
        cmd_valid = 1'b0;
        cmd       = '0;
        check("setup_psel_penable", {30'd0, PSEL, PENABLE}, 32'b10);
        check("setup_fields", {15'd0, PWRITE, PADDR, PWDATA}, {15'd0, v.wr, v.addr, v.data});
        check("setup_cmd_ready", 32'(cmd_ready), 32'd0);
        @(negedge PCLK);
        acc = 0; done = 0; unstable = 0;
        for (int c = 0; c < 64 && !done; c++) begin
            if (rsp_valid) begin
                done = 1;
            end else begin
                acc++;
                if (!(PSEL && PENABLE) || PADDR != v.addr || PWRITE != v.wr || PWDATA != v.data)
                    unstable = 1;
                if (acc == v.ws + 1) begin
                    PREADY  = 1'b1;
                    PRDATA  = v.prdata;
                    PSLVERR = v.perr;
                end else begin
                    PREADY  = 1'b0;
                    PRDATA  = DW'($urandom);
                    PSLVERR = 1'($urandom);
                end
                @(negedge PCLK);
                PREADY  = 1'b0;
                PSLVERR = 1'b0;
            end
        end
        check("rsp_arrived", 32'(done), 32'd1);
        check("access_stable", 32'(unstable), 32'd0);
        check("access_cycles", 32'(acc), 32'(v.e_acc));
        check("resp_apb_idle", {30'd0, PSEL, PENABLE}, 32'd0);
        check("resp_fields_held", {15'd0, PWRITE, PADDR, PWDATA}, {15'd0, v.wr, v.addr, v.data});
        check("rsp_data", 32'(rsp_data), 32'(v.e_data));
        check("rsp_err", 32'(rsp_err), 32'(v.e_err));
        d0 = rsp_data; e0 = rsp_err;
        for (int h = 0; h < v.hold; h++) begin
            @(negedge PCLK);
            check("bp_stable", {22'd0, rsp_valid, cmd_ready, rsp_err, rsp_data},
                  {22'd0, 1'b1, 1'b0, e0, d0});
        end
        rsp_ready = 1'b1;
        @(negedge PCLK);
        rsp_ready = 1'b0;
        check("after_rsp_valid", 32'(rsp_valid), 32'd0);
        check("after_rsp_cmd_ready", 32'(cmd_ready), 32'd1);
    endtask

    vec_t vecs [8];
    vec_t rv;
    int   t0;

    initial begin
        PRESET = 1'b1; cmd = '0; cmd_valid = 1'b0;
        PREADY = 1'b0; PRDATA = '0; PSLVERR = 1'b0; rsp_ready = 1'b0;

        //           wr    addr   data   ws  prdata perr hold  e_data e_err e_acc
        vecs[0] = '{1'b1, 7'h12, 8'hA5, 0,  8'h5A, 1'b0, 0, 8'h00, 1'b0, 1};
        vecs[1] = '{1'b0, 7'h05, 8'h00, 3,  8'h3C, 1'b0, 0, 8'h3C, 1'b0, 4};
        vecs[2] = '{1'b0, 7'h33, 8'h11, 1,  8'h77, 1'b1, 0, 8'h77, 1'b1, 2};
        vecs[3] = '{1'b1, 7'h7F, 8'hFF, 0,  8'h99, 1'b1, 0, 8'h00, 1'b1, 1};
        vecs[4] = '{1'b0, 7'h40, 8'h00, 99, 8'hEE, 1'b0, 0, 8'h00, 1'b1, 16};
        vecs[5] = '{1'b0, 7'h41, 8'h00, 15, 8'hC3, 1'b0, 0, 8'hC3, 1'b0, 16};
        vecs[6] = '{1'b1, 7'h00, 8'h5C, 15, 8'h12, 1'b0, 0, 8'h00, 1'b0, 16};
        vecs[7] = '{1'b0, 7'h2A, 8'h00, 0,  8'h81, 1'b0, 5, 8'h81, 1'b0, 1};

        #2;
        check("rst_apb", {15'd0, PSEL, PENABLE, PWRITE, PADDR, PWDATA}, 32'd0);
        check("rst_rsp", {22'd0, rsp_valid, rsp_err, rsp_data}, 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        @(negedge PCLK);
        @(negedge PCLK);
        PRESET = 1'b0;
        @(negedge PCLK);

        for (int i = 0; i < 8; i++) txn(vecs[i]);

        // Back-to-back: second command accepted exactly 4 cycles after the first.
        rv = '{1'b1, 7'h21, 8'h42, 0, 8'h00, 1'b0, 0, 8'h00, 1'b0, 1};
        txn(rv);
        t0 = accept_cyc;
        rv = '{1'b0, 7'h22, 8'h00, 0, 8'h6D, 1'b0, 0, 8'h6D, 1'b0, 1};
        txn(rv);
        check("b2b_spacing", 32'(accept_cyc - t0), 32'd4);

        // Reset asserted in ACCESS: PSEL drops at once, no response, next command is clean.
        cmd = {1'b0, 7'h55, 8'h00};
        cmd_valid = 1'b1;
        @(negedge PCLK);
        cmd_valid = 1'b0;
        @(negedge PCLK);
        check("pre_rst_in_access", {30'd0, PSEL, PENABLE}, 32'b11);
        #2 PRESET = 1'b1;
        #1;
        check("rst_mid_psel", {30'd0, PSEL, PENABLE}, 32'd0);
        check("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge PCLK);
        PRESET = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge PCLK);
            check("post_rst_idle", {29'd0, rsp_valid, PSEL, cmd_ready}, 32'b001);
        end
        txn(vecs[1]);

        // Randomized transfers against the reference model.
        for (int n = 0; n < 40; n++) begin
            rv.wr     = 1'($urandom);
            rv.addr   = AW'($urandom);
            rv.data   = DW'($urandom);
            rv.ws     = int'($urandom_range(0, 19));
            rv.prdata = DW'($urandom);
            rv.perr   = 1'($urandom);
            rv.hold   = int'($urandom_range(0, 3));
            rv.e_data = ref_data(rv.wr, rv.ws, rv.prdata);
            rv.e_err  = ref_err(rv.ws, rv.perr);
            rv.e_acc  = ref_acc(rv.ws);
            txn(rv);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
